// File: rtl/imem_fetch_bridge_if.sv
// Fetch-port and SRAM-port signal bundle for the instruction fetch bridge.
// The bridge takes the slave view: it answers the core's fetch requests and
// drives the SRAM read port. The environment (core + SRAM) takes the master view.
interface imem_fetch_bridge_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 20
);
  // core side
  logic                  flush_i;
  logic                  fetch_addr_valid;
  logic                  fetch_addr_ready;
  logic [XLEN-1:0]       fetch_addr;
  logic                  fetch_data_valid;
  logic                  fetch_data_ready;
  logic [31:0]           fetch_data;
  logic                  fetch_err;
  // SRAM side
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_rdata;

  modport slave (
    input  flush_i, fetch_addr_valid, fetch_addr, fetch_data_ready, mem_rdata,
    output fetch_addr_ready, fetch_data_valid, fetch_data, fetch_err, mem_en, mem_addr
  );

  modport master (
    output flush_i, fetch_addr_valid, fetch_addr, fetch_data_ready, mem_rdata,
    input  fetch_addr_ready, fetch_data_valid, fetch_data, fetch_err, mem_en, mem_addr
  );
endinterface

// File: rtl/imem_fetch_bridge.sv
// Instruction fetch bridge: core fetch port <-> 1-cycle-latency instruction SRAM.
// Requests are issued to the SRAM in the accept cycle; the SRAM word returns one
// cycle later and either falls straight through to the core or is parked in a
// small response FIFO. Acceptance is credit-limited so the FIFO never overflows.
module imem_fetch_bridge #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int DEPTH      = 2
) (
  input  logic                clk,
  input  logic                rst,
  imem_fetch_bridge_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);             // occupancy counter width
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1; // pointer width

  // registered state
  logic [CW-1:0] occ_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic          inflight_q;
  logic          inflight_err_q;
  logic [31:0]   fifo_data [DEPTH];
  logic          fifo_err  [DEPTH];

  // combinational helpers
  logic          addr_hi_bad;
  logic          req_err;
  logic          accept;
  logic [CW:0]   credit_used;
  logic          fifo_empty;
  logic [31:0]   resp_word;
  logic          head_err;
  logic [31:0]   head_data;
  logic          push;
  logic          pop;

  // Out-of-range check only exists when the fetch address is wider than the SRAM range.
  generate
    if (XLEN > ADDR_WIDTH + 2) begin : g_hi_check
      assign addr_hi_bad = |bus.fetch_addr[XLEN-1:ADDR_WIDTH+2];
    end else begin : g_no_hi_check
      assign addr_hi_bad = 1'b0;
    end
  endgenerate

  assign req_err     = (bus.fetch_addr[1:0] != 2'b00) || addr_hi_bad;
  assign credit_used = {1'b0, occ_q} + {{CW{1'b0}}, inflight_q};
  assign fifo_empty  = (occ_q == '0);

  // Responses already promised (queued plus in flight) must fit in the FIFO.
  assign bus.fetch_addr_ready = !rst && !bus.flush_i && (credit_used < (CW+1)'(DEPTH));
  assign accept               = bus.fetch_addr_valid && bus.fetch_addr_ready;

  // Error requests never touch the SRAM; they still occupy a response slot.
  assign bus.mem_en   = accept && !req_err;
  assign bus.mem_addr = bus.fetch_addr[ADDR_WIDTH+1:2];

  // The word returning from the SRAM this cycle; error responses carry zero.
  assign resp_word = inflight_err_q ? 32'h0 : bus.mem_rdata;

  // Head of queue: FIFO entry if any, else the response falling through.
  always_comb begin
    head_data = resp_word;
    head_err  = inflight_err_q;
    if (!fifo_empty) begin
      head_data = fifo_data[rd_ptr_q];
      head_err  = fifo_err[rd_ptr_q];
    end
  end

  assign bus.fetch_data_valid = !rst && !bus.flush_i && (!fifo_empty || inflight_q);
  assign bus.fetch_data       = bus.fetch_data_valid ? head_data : 32'h0;
  assign bus.fetch_err        = bus.fetch_data_valid && head_err;

  // Pop only real FIFO entries; a consumed fall-through response is never stored.
  assign pop  = bus.fetch_data_valid && bus.fetch_data_ready && !fifo_empty;
  assign push = inflight_q && !bus.flush_i && !(fifo_empty && bus.fetch_data_ready);

  // Control state: occupancy, wrapping pointers and the in-flight marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q          <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
    end else if (bus.flush_i) begin
      occ_q          <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
    end else begin
      inflight_q     <= accept;
      inflight_err_q <= req_err;
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // FIFO storage: plain register array, written at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= resp_word;
      fifo_err[wr_ptr_q]  <= inflight_err_q;
    end
  end

  // The credit check must make an overflowing push impossible.
  no_overflow_a : assert property (
    @(posedge clk) disable iff (rst) !(push && !pop && (occ_q == CW'(DEPTH)))
  );

endmodule

// File: tb/tb_imem_fetch_bridge.sv
// Self-checking bench for imem_fetch_bridge: directed vector table, directed
// corner sequences and randomized traffic against a queue-based reference.
module tb_imem_fetch_bridge;

  localparam int XLEN  = 32;
  localparam int AW    = 20;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  imem_fetch_bridge_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();

  imem_fetch_bridge #(.XLEN(XLEN), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: word i holds 0x1000+i; idle cycles return garbage.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= 32'h1000 + {12'h0, bus.mem_addr};
    else            bus.mem_rdata <= $urandom;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h1000 + {12'h0, a[21:2]};
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:22] != 10'h0);
  endfunction

  task automatic drive(input logic fl, input logic av, input logic [31:0] a, input logic dr);
    bus.flush_i          = fl;
    bus.fetch_addr_valid = av;
    bus.fetch_addr       = a;
    bus.fetch_data_ready = dr;
  endtask

  // Compare the core/SRAM-visible outputs against expectations.
  task automatic check(input string tag, input logic ar, input logic dv, input logic [31:0] d,
                       input logic e, input logic men, input logic [AW-1:0] ma);
    logic ok;
    ok = (bus.fetch_addr_ready === ar) && (bus.fetch_data_valid === dv) && (bus.mem_en === men);
    if (dv) ok = ok && (bus.fetch_data === d) && (bus.fetch_err === e);
    if (men) ok = ok && (bus.mem_addr === ma);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got ar=%b dv=%b data=%h err=%b men=%b maddr=%h want ar=%b dv=%b data=%h err=%b men=%b maddr=%h",
               tag, bus.fetch_addr_ready, bus.fetch_data_valid, bus.fetch_data, bus.fetch_err,
               bus.mem_en, bus.mem_addr, ar, dv, d, e, men, ma);
    end else begin
      $display("ok   %s ar=%b dv=%b data=%h err=%b men=%b", tag, ar, dv, d, e, men);
    end
  endtask

  // ---------------- reference model: list of promised responses ----------------
  typedef struct packed { logic [31:0] d; logic e; } resp_t;
  resp_t model_q[$];

  // One cycle: drive inputs, check against the model, then advance the model at the edge.
  task automatic mstep(input string tag, input logic fl, input logic av, input logic [31:0] a,
                       input logic dr, output logic accepted);
    logic ar, dv, men;
    resp_t head;
    drive(fl, av, a, dr);
    ar  = !fl && (model_q.size() < DEPTH);
    dv  = !fl && (model_q.size() > 0);
    head = dv ? model_q[0] : '0;
    men = av && ar && !addr_bad(a);
    @(negedge clk);
    check(tag, ar, dv, head.d, head.e, men, a[AW+1:2]);
    accepted = av && ar;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (dv && dr) void'(model_q.pop_front());
      if (accepted) model_q.push_back(addr_bad(a) ? resp_t'{32'h0, 1'b1} : resp_t'{word_of(a), 1'b0});
    end
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        fl;
    logic        av;
    logic [31:0] addr;
    logic        dr;
    logic        ar;
    logic        dv;
    logic [31:0] data;
    logic        err;
    logic        men;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  initial begin
    logic acc;
    int   nxt;
    //         fl  av  addr           dr  ar  dv  data          err men
    // stream
    vt[0]  = '{1'b0,1'b1,32'h0000_0000,1'b1,1'b1,1'b0,32'h0,        1'b0,1'b1};
    vt[1]  = '{1'b0,1'b1,32'h0000_0004,1'b1,1'b1,1'b1,32'h0000_1000,1'b0,1'b1};
    vt[2]  = '{1'b0,1'b1,32'h0000_0008,1'b1,1'b1,1'b1,32'h0000_1001,1'b0,1'b1};
    vt[3]  = '{1'b0,1'b1,32'h0000_000C,1'b1,1'b1,1'b1,32'h0000_1002,1'b0,1'b1};
    vt[4]  = '{1'b0,1'b0,32'h0000_0000,1'b1,1'b1,1'b1,32'h0000_1003,1'b0,1'b0};
    // backpressure
    vt[5]  = '{1'b0,1'b1,32'h0000_0000,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1};
    vt[6]  = '{1'b0,1'b1,32'h0000_0004,1'b0,1'b1,1'b1,32'h0000_1000,1'b0,1'b1};
    vt[7]  = '{1'b0,1'b1,32'h0000_0008,1'b0,1'b0,1'b1,32'h0000_1000,1'b0,1'b0};
    vt[8]  = '{1'b0,1'b1,32'h0000_0008,1'b1,1'b0,1'b1,32'h0000_1000,1'b0,1'b0};
    vt[9]  = '{1'b0,1'b1,32'h0000_0008,1'b1,1'b1,1'b1,32'h0000_1001,1'b0,1'b1};
    vt[10] = '{1'b0,1'b0,32'h0000_0000,1'b1,1'b1,1'b1,32'h0000_1002,1'b0,1'b0};
    // errors
    vt[11] = '{1'b0,1'b1,32'h0000_0002,1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0};
    vt[12] = '{1'b0,1'b1,32'h0040_0000,1'b1,1'b1,1'b1,32'h0,        1'b1,1'b0};
    vt[13] = '{1'b0,1'b1,32'h0000_0004,1'b1,1'b1,1'b1,32'h0,        1'b1,1'b1};
    vt[14] = '{1'b0,1'b0,32'h0000_0000,1'b1,1'b1,1'b1,32'h0000_1001,1'b0,1'b0};
    // flush with two queued entries
    vt[15] = '{1'b0,1'b1,32'h0000_0000,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1};
    vt[16] = '{1'b0,1'b1,32'h0000_0004,1'b0,1'b1,1'b1,32'h0000_1000,1'b0,1'b1};
    vt[17] = '{1'b0,1'b0,32'h0000_0000,1'b0,1'b0,1'b1,32'h0000_1000,1'b0,1'b0};
    vt[18] = '{1'b1,1'b1,32'h0000_0008,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0};
    vt[19] = '{1'b0,1'b1,32'h0000_0010,1'b1,1'b1,1'b0,32'h0,        1'b0,1'b1};
    vt[20] = '{1'b0,1'b0,32'h0000_0000,1'b1,1'b1,1'b1,32'h0000_1004,1'b0,1'b0};
    // flush while a response is in flight
    vt[21] = '{1'b0,1'b1,32'h0000_0000,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1};
    vt[22] = '{1'b1,1'b0,32'h0000_0000,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0};
    vt[23] = '{1'b0,1'b0,32'h0000_0000,1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0};

    // reset state, with a request already presented
    drive(1'b0, 1'b1, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    total++;
    if (bus.fetch_data !== 32'h0 || bus.fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_data got data=%h err=%b want data=0 err=0", bus.fetch_data, bus.fetch_err);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].fl, vt[i].av, vt[i].addr, vt[i].dr);
      @(negedge clk);
      check($sformatf("vec%0d", i), vt[i].ar, vt[i].dv, vt[i].data, vt[i].err, vt[i].men,
            vt[i].addr[AW+1:2]);
      @(posedge clk);
      #1;
    end

    // simultaneous push/pop and pointer wrap across 10 fetches
    model_q.delete();
    mstep("wrap_a", 1'b0, 1'b1, 32'h0, 1'b0, acc);
    mstep("wrap_b", 1'b0, 1'b1, 32'h4, 1'b0, acc);
    nxt = 2;
    for (int k = 0; k < 40 && nxt < 10; k++) begin
      mstep($sformatf("wrap%0d", nxt), 1'b0, 1'b1, 32'(nxt * 4), 1'b1, acc);
      if (acc) nxt++;
    end
    for (int k = 0; k < 3; k++) mstep("wrap_drain", 1'b0, 1'b0, 32'h0, 1'b1, acc);

    // async reset mid-stream
    mstep("rs_a", 1'b0, 1'b1, 32'h0, 1'b0, acc);
    mstep("rs_b", 1'b0, 1'b1, 32'h4, 1'b0, acc);
    drive(1'b0, 1'b1, 32'h30, 1'b1);
    #3 rst = 1'b1;
    #1;
    total++;
    if (bus.fetch_data_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.fetch_addr_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got dv=%b men=%b ar=%b want 0 0 0",
               bus.fetch_data_valid, bus.mem_en, bus.fetch_addr_ready);
    end else begin
      $display("ok   async_rst outputs low immediately");
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_q.delete();
    mstep("post_rst_a", 1'b0, 1'b1, 32'h20, 1'b1, acc);
    mstep("post_rst_b", 1'b0, 1'b0, 32'h0, 1'b1, acc);
    mstep("post_rst_c", 1'b0, 1'b0, 32'h0, 1'b1, acc);

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = {22'($urandom_range(0, 63)), 8'h0, 2'($urandom_range(1, 3))};
      else if (sel == 1) a = 32'h0040_0000 | {$urandom_range(0, 255), 2'b00};
      else               a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      mstep($sformatf("rnd%0d", n), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            a, $urandom_range(0, 1) == 1, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
